// File: rtl/watch_disp_pkg.sv
// Shared constants and types for the watch display scanner:
// hex-to-segment codes, the blank code and the per-slot scan state.
package watch_disp_pkg;

    // Active-high {g,f,e,d,c,b,a} codes, indexed by nibble value.
    localparam logic [7:0] SEG_CODES [16] = '{
        8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
        8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71
    };

    localparam logic [7:0] SEG_BLANK = 8'h00;

    typedef enum logic {
        BLANK = 1'b0,
        DRIVE = 1'b1
    } scan_state_t;

endpackage

// File: rtl/seg_decode.sv
// Combinational hex nibble plus decimal point to active-high segment code.
module seg_decode
    import watch_disp_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       point,
    output logic [7:0] code
);

    assign code = {point, SEG_CODES[nibble][6:0]};

endmodule

// File: rtl/seg_scan.sv
// Time-multiplexed seven-segment scanner: one digit per slot, a blank
// interval at the start of each slot, frame-latched inputs and live blink.
module seg_scan
    import watch_disp_pkg::*;
#(
    parameter int CLK_HZ     = 50_000_000,
    parameter int NDIG       = 6,
    parameter int DIGIT_HZ   = 6000,
    parameter int BLANK_CYC  = 50,
    parameter int ACTIVE_LOW = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic [4*NDIG-1:0] digits,
    input  logic [NDIG-1:0]   dp,
    input  logic [NDIG-1:0]   blink_mask,
    input  logic              flash,
    output logic [7:0]        seg,
    output logic [NDIG-1:0]   an,
    output logic              frame_tick,
    output scan_state_t       state
);

    localparam int PRESCALE = CLK_HZ / DIGIT_HZ;
    localparam int SC_W     = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int IDX_W    = (NDIG > 1) ? $clog2(NDIG) : 1;

    localparam logic [SC_W-1:0]  SC_MAX    = SC_W'(PRESCALE - 1);
    // BLANK_CYC must be at least 1 so the slot always opens in BLANK.
    localparam logic [SC_W-1:0]  SC_PRE_DR = SC_W'(BLANK_CYC - 1);
    localparam logic [IDX_W-1:0] IDX_MAX   = IDX_W'(NDIG - 1);

    logic [SC_W-1:0]   sc;
    logic [IDX_W-1:0]  idx;
    scan_state_t       state_q;
    logic [4*NDIG-1:0] dig_sh;
    logic [NDIG-1:0]   dp_sh;
    logic [NDIG-1:0]   blink_sh;
    logic              flash_q;
    logic [7:0]        seg_q;
    logic [NDIG-1:0]   an_q;
    logic              tick_q;

    logic              frame_start;
    logic [4*NDIG-1:0] dig_cur;
    logic [NDIG-1:0]   dp_cur;
    logic [NDIG-1:0]   blink_cur;
    logic [3:0]        nibble;
    logic              dp_bit;
    logic              blink_bit;
    logic [NDIG-1:0]   an_next;
    logic [7:0]        code;

    // On the shadow-load cycle the fresh inputs are what the shadows will hold.
    assign frame_start = (sc == '0) && (idx == '0);
    assign dig_cur     = frame_start ? digits     : dig_sh;
    assign dp_cur      = frame_start ? dp         : dp_sh;
    assign blink_cur   = frame_start ? blink_mask : blink_sh;

    always_comb begin
        nibble    = 4'h0;
        dp_bit    = 1'b0;
        blink_bit = 1'b0;
        an_next   = '0;
        for (int i = 0; i < NDIG; i++) begin
            if (idx == IDX_W'(i)) begin
                nibble     = dig_cur[4*i +: 4];
                dp_bit     = dp_cur[i];
                blink_bit  = blink_cur[i];
                an_next[i] = 1'b1;
            end
        end
    end

    seg_decode u_decode (
        .nibble (nibble),
        .point  (dp_bit),
        .code   (code)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            sc       <= '0;
            idx      <= '0;
            state_q  <= BLANK;
            dig_sh   <= '0;
            dp_sh    <= '0;
            blink_sh <= '0;
            flash_q  <= 1'b0;
            seg_q    <= SEG_BLANK;
            an_q     <= '0;
            tick_q   <= 1'b0;
        end else begin
            flash_q <= flash;
            if (!enable) begin
                sc      <= '0;
                idx     <= '0;
                state_q <= BLANK;
                seg_q   <= SEG_BLANK;
                an_q    <= '0;
                tick_q  <= 1'b0;
            end else begin
                if (frame_start) begin
                    dig_sh   <= digits;
                    dp_sh    <= dp;
                    blink_sh <= blink_mask;
                end
                tick_q <= frame_start;

                if (state_q == DRIVE) begin
                    an_q  <= an_next;
                    seg_q <= (blink_bit && !flash_q) ? SEG_BLANK : code;
                end else begin
                    an_q  <= '0;
                    seg_q <= SEG_BLANK;
                end

                if (sc == SC_MAX) begin
                    sc      <= '0;
                    idx     <= (idx == IDX_MAX) ? '0 : idx + IDX_W'(1);
                    state_q <= BLANK;
                end else begin
                    sc <= sc + SC_W'(1);
                    if (sc == SC_PRE_DR) begin
                        state_q <= DRIVE;
                    end
                end
            end
        end
    end

    assign seg        = (ACTIVE_LOW != 0) ? ~seg_q : seg_q;
    assign an         = (ACTIVE_LOW != 0) ? ~an_q  : an_q;
    assign frame_tick = tick_q;
    assign state      = state_q;

endmodule

// File: tb/tb_seg_scan.sv
// Directed bench for seg_scan with a per-cycle scoreboard; a second,
// active-low instance showing digit 0 checks pin polarity alongside.
module tb_seg_scan;
    import watch_disp_pkg::*;

    localparam int NDIG  = 6;
    localparam int PRE   = 12;
    localparam int BLK   = 2;
    localparam int FRAME = NDIG * PRE;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        enable;
    logic        flash;
    logic [23:0] digits;
    logic [5:0]  dp;
    logic [5:0]  blink_mask;
    logic [7:0]  seg;
    logic [5:0]  an;
    logic        frame_tick;
    scan_state_t st;
    logic [7:0]  al_seg;
    logic [5:0]  al_an;
    logic        al_tick;
    scan_state_t al_st;

    seg_scan #(
        .CLK_HZ(1200), .NDIG(NDIG), .DIGIT_HZ(100), .BLANK_CYC(BLK), .ACTIVE_LOW(0)
    ) u_dut (
        .clk(clk), .reset(reset), .enable(enable), .digits(digits), .dp(dp),
        .blink_mask(blink_mask), .flash(flash), .seg(seg), .an(an),
        .frame_tick(frame_tick), .state(st)
    );

    seg_scan #(
        .CLK_HZ(1200), .NDIG(NDIG), .DIGIT_HZ(100), .BLANK_CYC(BLK), .ACTIVE_LOW(1)
    ) u_dut_al (
        .clk(clk), .reset(reset), .enable(enable), .digits(24'h000000), .dp(6'b000000),
        .blink_mask(6'b000000), .flash(1'b1), .seg(al_seg), .an(al_an),
        .frame_tick(al_tick), .state(al_st)
    );

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int last_tick_cyc = -1;
    int tick_gap = 0;
    int m_t = 0;
    int flash_cnt = 0;
    logic flash_auto = 1'b0;
    logic [23:0] m_dig = '0;
    logic [5:0]  m_dp = '0;
    logic [5:0]  m_blink = '0;
    logic        m_flash = 1'b0;
    logic [29:0] exp_q[$];

    function automatic logic [7:0] hex7(input logic [3:0] v);
        case (v)
            4'h0: return 8'h3F;  4'h1: return 8'h06;  4'h2: return 8'h5B;  4'h3: return 8'h4F;
            4'h4: return 8'h66;  4'h5: return 8'h6D;  4'h6: return 8'h7D;  4'h7: return 8'h07;
            4'h8: return 8'h7F;  4'h9: return 8'h6F;  4'hA: return 8'h77;  4'hB: return 8'h7C;
            4'hC: return 8'h39;  4'hD: return 8'h5E;  4'hE: return 8'h79;  default: return 8'h71;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Expected outputs for the coming clock edge, from frame position arithmetic.
    task automatic model_push();
        int pos;
        int i;
        int s;
        logic       tk;
        logic [5:0] a;
        logic [7:0] sg;
        logic [7:0] al_sg;
        tk = 1'b0;
        a  = '0;
        sg = '0;
        if (reset) begin
            m_t = 0; m_dig = '0; m_dp = '0; m_blink = '0; m_flash = 1'b0;
        end else if (!enable) begin
            m_t = 0;
            m_flash = flash;
        end else begin
            pos = m_t % FRAME;
            i   = pos / PRE;
            s   = pos % PRE;
            if (pos == 0) begin
                m_dig = digits; m_dp = dp; m_blink = blink_mask;
            end
            tk = (pos == 0);
            if (s >= BLK) begin
                a = 6'(1 << i);
                if (!(m_blink[i] && !m_flash))
                    sg = hex7(m_dig[i*4 +: 4]) | {m_dp[i], 7'b0};
            end
            m_t++;
            m_flash = flash;
        end
        al_sg = (a != '0) ? 8'h3F : 8'h00;
        exp_q.push_back({tk, a, sg, tk, ~a, ~al_sg});
    endtask

    task automatic step();
        logic [29:0] o;
        logic [29:0] e;
        if (flash_auto) begin
            if (flash_cnt == 36) begin
                flash = ~flash;
                flash_cnt = 0;
            end
            flash_cnt++;
        end
        model_push();
        @(posedge clk);
        #1;
        cyc++;
        o = {frame_tick, an, seg, al_tick, al_an, al_seg};
        check("sb_depth", 32'(exp_q.size()), 32'd1);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("scoreboard", 32'(o), 32'(e));
        end
        if (frame_tick) begin
            if (last_tick_cyc >= 0) tick_gap = cyc - last_tick_cyc;
            last_tick_cyc = cyc;
        end
    endtask

    task automatic run_to(input int target);
        int guard;
        guard = 0;
        while ((m_t % FRAME) != target && guard < 2 * FRAME) begin
            step();
            guard++;
        end
        check("run_to_bound", 32'(m_t % FRAME), 32'(target));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; enable = 1'b1; flash = 1'b1;
        digits = 24'h123456; dp = 6'b000100; blink_mask = 6'b000000;

        // Reset held three cycles.
        repeat (3) begin
            step();
            check("rst_seg", 32'(seg), 32'h00);
            check("rst_an", 32'(an), 32'h00);
            check("rst_tick", 32'(frame_tick), 32'h0);
        end
        check("rst_state", 32'(st), 32'(BLANK));
        check("rst_al_seg", 32'(al_seg), 32'hFF);
        check("rst_al_an", 32'(al_an), 32'h3F);

        // Basic scan.
        reset = 1'b0;
        step();
        check("scan_tick0", 32'(frame_tick), 32'h1);
        check("scan_blank0_an", 32'(an), 32'h00);
        check("pol_blank_seg", 32'(al_seg), 32'hFF);
        check("pol_blank_an", 32'(al_an), 32'h3F);
        step();
        check("scan_blank1_an", 32'(an), 32'h00);
        step();
        check("scan_d0_an", 32'(an), 32'h01);
        check("scan_d0_seg", 32'(seg), 32'h7D);
        check("scan_state_drive", 32'(st), 32'(DRIVE));
        check("pol_drive_seg", 32'(al_seg), 32'hC0);
        check("pol_drive_an", 32'(al_an), 32'h3E);
        run_to(11);
        step();
        check("scan_d0_last_an", 32'(an), 32'h01);
        step();
        check("scan_gap_an", 32'(an), 32'h00);
        step();
        check("scan_gap2_an", 32'(an), 32'h00);
        step();
        check("scan_d1_an", 32'(an), 32'h02);
        check("scan_d1_seg", 32'(seg), 32'h6D);
        run_to(26);
        step();
        check("scan_d2_dp_seg", 32'(seg), 32'hE6);
        run_to(0);
        step();
        check("scan_period", 32'(tick_gap), 32'd72);

        // Blink on digits 0 and 1; mask loads at the next frame.
        blink_mask = 6'b000011;
        run_to(0);
        step();
        run_to(5);
        flash = 1'b0;
        step();
        check("blink_lat1_seg", 32'(seg), 32'h7D);
        step();
        check("blink_off_seg", 32'(seg), 32'h00);
        check("blink_off_an", 32'(an), 32'h01);
        flash = 1'b1;
        step();
        check("blink_on_lat1_seg", 32'(seg), 32'h00);
        step();
        check("blink_on_seg", 32'(seg), 32'h7D);
        flash = 1'b0;
        run_to(14);
        step();
        check("blink_d1_seg", 32'(seg), 32'h00);
        check("blink_d1_an", 32'(an), 32'h02);
        run_to(26);
        step();
        check("blink_d2_unaff", 32'(seg), 32'hE6);
        flash = 1'b1;
        flash_auto = 1'b1;
        flash_cnt = 0;
        repeat (2 * FRAME) step();
        flash_auto = 1'b0;
        flash = 1'b1;

        // Tear-free update mid-frame.
        blink_mask = 6'b000000;
        run_to(0);
        step();
        run_to(41);
        digits = 24'h999999;
        run_to(50);
        step();
        check("tear_d4_old", 32'(seg), 32'h5B);
        run_to(62);
        step();
        check("tear_d5_old", 32'(seg), 32'h06);
        run_to(2);
        step();
        check("tear_d0_new", 32'(seg), 32'h6F);
        check("tear_d0_an", 32'(an), 32'h01);
        run_to(62);
        step();
        check("tear_d5_new", 32'(seg), 32'h6F);
        check("tear_d5_an", 32'(an), 32'h20);

        // Enable drop during DRIVE of digit 4, then restart.
        run_to(52);
        enable = 1'b0;
        step();
        check("en_off_an", 32'(an), 32'h00);
        check("en_off_seg", 32'(seg), 32'h00);
        check("en_off_state", 32'(st), 32'(BLANK));
        repeat (3) step();
        enable = 1'b1;
        step();
        check("en_on_tick", 32'(frame_tick), 32'h1);
        check("en_on_an", 32'(an), 32'h00);
        run_to(2);
        step();
        check("en_on_d0_an", 32'(an), 32'h01);
        check("en_on_d0_seg", 32'(seg), 32'h6F);
        repeat (FRAME) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/seg_scan.md
# seg_scan

Time-multiplexed seven-segment display driver for the watch. It takes packed BCD/hex digits, a decimal-point mask and a per-digit blink mask. The blink gate comes from an upstream `Flash` pwm output and blanks the digits under edit. The block scans one digit per slot and inserts an anti-ghosting blank interval, driving the board's segment and digit-enable pins. It sits downstream of the time-keeping counters and `Flash`, and directly upstream of the pins.

## Interface
- `CLK_HZ`, 50_000_000: clock frequency.
- `NDIG`, 6: number of digits; digit 0 is the rightmost digit.
- `DIGIT_HZ`, 6000: slot rate. Slot length `PRESCALE = CLK_HZ/DIGIT_HZ` cycles (8333 by default).
- `BLANK_CYC`, 50: cycles at the start of each slot during which all digits are off. Requires `BLANK_CYC < PRESCALE`.
- `ACTIVE_LOW`, 1: when 1, `seg` and `an` are both inverted at the pins.
- `clk` input 1: system clock. Single clock domain.
- `reset` input 1: synchronous, active-high.
- `enable` input 1: when low, the display is dark and the scan restarts.
- `digits` input 4*NDIG: nibble i, bits [4i+3:4i], is the value of digit i (0–F).
- `dp` input NDIG: decimal-point request per digit.
- `blink_mask` input NDIG: 1 = the digit blinks with `flash`.
- `flash` input 1: blink gate (`Flash.pwm`). 1 = visible.
- `seg` output 8: {dp,g,f,e,d,c,b,a}, logical 1 = lit, before polarity is applied.
- `an` output NDIG: one-hot digit enable, logical 1 = on, before polarity is applied.
- `frame_tick` output 1: one-cycle pulse when digit 0's slot begins.

## Operation
- Counters:
  - Slot counter `sc`: 0..PRESCALE-1, wraps.
  - Digit index `idx`: 0..NDIG-1. It increments when `sc` wraps and wraps from NDIG-1 to 0.
- FSM per slot:
  - BLANK while `sc < BLANK_CYC`: `an` all off, `seg` all off.
  - DRIVE for the rest of the slot: `an[idx]`=1.
  - BLANK→DRIVE occurs at `sc == BLANK_CYC`. DRIVE→BLANK occurs at the `sc` wrap.
- Shadow registers:
  - `digits`, `dp` and `blink_mask` are latched into shadow registers on the cycle where `sc==0 && idx==0`, which is also the `frame_tick` cycle.
  - Input changes mid-frame have no effect until the next frame. This prevents tearing.
- Decode: the shadow nibble is hex-decoded in active-high segment codes:
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07
  - 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71
  - `seg[7]` = `dp` shadow bit.
- Blink:
  - `flash` is registered once and applied live, not latched per frame.
  - If `blink_mask` shadow[idx]=1 and registered flash=0, `seg` is forced all off. `an` still drives normally.
- Enable low:
  - Next cycle, outputs go dark; `sc`, `idx` and FSM return to their reset values.
  - On re-enable, the first cycle is `sc=0, idx=0`. `frame_tick` pulses and the shadow registers load.
- Reset dominates `enable`.
- Reset values (logical): `seg`=0, `an`=0, `frame_tick`=0, `sc`=0, `idx`=0, FSM=BLANK, shadows=0, flash register=0. At the pins, `seg` and `an` read all 1s when `ACTIVE_LOW`=1.

## Timing
- All outputs are registered. Pins reflect the counter state of the previous cycle, a latency of 1 cycle.
- Frame length is NDIG*PRESCALE cycles; the default is 49998 cycles, about 1.0 kHz.
- On-time per digit is PRESCALE-BLANK_CYC cycles. `an` never has two bits set; one-hot is guaranteed by construction.
- `flash` to `seg` latency is 2 cycles: one for the synchronizing register, one for the output register.
- `frame_tick` is asserted in the output cycle corresponding to `sc==0, idx==0`.
- Widths:
  - `sc` is `$clog2(PRESCALE)` bits.
  - `idx` is `$clog2(NDIG)` bits, minimum 1.
  - Compares are against constants only; no dividers.

## Structure
- Package `watch_disp_pkg`:
  - The 16-entry segment code constants.
  - A blank constant (8'h00).
  - The FSM state enum {BLANK, DRIVE}.
- Sub-module `seg_decode`: combinational nibble+dp → 8-bit code.
- The slot counter may be an instance of the existing `Counter` with `MAX=PRESCALE-1`, `UP=1`.

## Test plan
Sim parameters: `CLK_HZ`=1200, `DIGIT_HZ`=100 (`PRESCALE`=12), `NDIG`=6, `BLANK_CYC`=2, `ACTIVE_LOW`=0.
- Reset: hold `reset` 3 cycles with `enable`=1 → `seg`=00, `an`=00, `frame_tick`=0 throughout.
- Basic scan: release reset with `digits`=24'h123456, `dp`=6'b000100, no blink. Required response:
  - `frame_tick` at the first output cycle.
  - `an`=00 for 2 cycles, then `an`=01 with `seg`=7D for 10 cycles.
  - Then 2 blank cycles, then `an`=02 with `seg`=6D.
  - Digit 2 shows `seg`=E6 (66 with dp set).
  - Period is 72 cycles.
- Blink: `blink_mask`=6'b000011 with `flash` toggling every 36 cycles → digits 0–1 show `seg`=00 while `flash`=0. The response follows a flash edge after 2 cycles; other digits are unaffected.
- Tear-free update: change `digits` to 24'h999999 mid-frame during idx=3 → digits 4–5 keep their old values until the next `frame_tick`, then all show 6F.
- Enable drop: deassert `enable` during DRIVE of idx=4 → next cycle `an`=00 and `seg`=00. Re-enable → `frame_tick` on the first cycle, scan restarts at idx 0.
- Polarity: `ACTIVE_LOW`=1, `digits`=0 → `seg`=C0 and `an`=3E while digit 0 is driven; during BLANK, `seg`=FF and `an`=3F.
